// File: rtl/sr_cmd_ctrl_pkg.sv
// Shared types for the SR latch command controller: FSM states, command codes,
// latch drive encodings and the set/clear collision arbiter.
package sr_cmd_pkg;

  typedef enum logic [1:0] {IDLE, SET_P, CLR_P, GAP} state_t;
  typedef enum logic [1:0] {CMD_NONE, CMD_SET, CMD_CLR} cmd_t;

  localparam logic [1:0] SR_HOLD = 2'b00;
  localparam logic [1:0] SR_CLR  = 2'b01;
  localparam logic [1:0] SR_SET  = 2'b10;

  function automatic cmd_t arbitrate(input logic set_stb, input logic clr_stb,
                                     input logic clr_prio);
    cmd_t cmd;
    cmd = CMD_NONE;
    if (set_stb && clr_stb) cmd = clr_prio ? CMD_CLR : CMD_SET;
    else if (set_stb)       cmd = CMD_SET;
    else if (clr_stb)       cmd = CMD_CLR;
    return cmd;
  endfunction

endpackage

// File: rtl/sr_cmd_ctrl_if.sv
// Request/drive bundle between the request source and the SR latch controller.
interface sr_cmd_ctrl_if;
  logic set_req;
  logic clr_req;
  logic s;
  logic r;
  logic en;
  logic busy;
  logic conflict;
  logic q_exp;

  modport master (output set_req, clr_req,
                  input  s, r, en, busy, conflict, q_exp);
  modport slave  (input  set_req, clr_req,
                  output s, r, en, busy, conflict, q_exp);
endinterface

// File: rtl/sr_cmd_ctrl_debounce.sv
// One request lane: 2-flop synchroniser, debounce counter and a registered
// one-cycle strobe on the debounced rising edge.
module sr_debounce #(
  parameter int unsigned DEB_CYC = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_rise
);

  localparam int unsigned    CW       = $clog2(DEB_CYC + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEB_CYC - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_level_q;
  logic          r_rise;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_level   <= 1'b0;
      r_level_q <= 1'b0;
      r_rise    <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync1   <= i_async;
      r_sync2   <= r_sync1;
      r_level_q <= r_level;
      r_rise    <= r_level & ~r_level_q;
      // r_cnt counts consecutive disagreeing samples; any agreement restarts it
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_rise = r_rise;

endmodule

// File: rtl/sr_cmd_ctrl.sv
// SR latch command controller: debounced set/clear strobes are arbitrated, held in a
// one-deep pending slot and played out as fixed-width, mutually exclusive s/r pulses.
module sr_cmd_ctrl
  import sr_cmd_pkg::*;
#(
  parameter int unsigned DEB_CYC      = 4,
  parameter int unsigned PULSE_CYC    = 2,
  parameter int unsigned GAP_CYC      = 1,
  parameter bit          CLR_PRIORITY = 1'b1
) (
  input logic          clk,
  input logic          rst,
  sr_cmd_ctrl_if.slave bus
);

  localparam int unsigned   CMAX     = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
  localparam int unsigned   CW       = $clog2(CMAX + 1);
  localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_CYC - 1);
  localparam logic [CW-1:0] GAP_LD   = CW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  logic          w_set_stb;
  logic          w_clr_stb;
  cmd_t          w_new_cmd;
  cmd_t          w_go_cmd;
  logic          w_go;
  state_t        r_state;
  state_t        w_state_nxt;
  cmd_t          r_pend;
  cmd_t          w_pend_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [1:0]    r_sr;
  logic [1:0]    w_sr_nxt;
  logic          r_q_exp;
  logic          w_q_exp_nxt;
  logic          r_en;
  logic          r_busy;
  logic          r_conflict;

  sr_debounce #(.DEB_CYC(DEB_CYC)) u_deb_set (
    .clk(clk), .rst(rst), .i_async(bus.set_req), .o_rise(w_set_stb)
  );

  sr_debounce #(.DEB_CYC(DEB_CYC)) u_deb_clr (
    .clk(clk), .rst(rst), .i_async(bus.clr_req), .o_rise(w_clr_stb)
  );

  assign w_new_cmd = arbitrate(w_set_stb, w_clr_stb, CLR_PRIORITY);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pend_nxt  = r_pend;
    w_q_exp_nxt = r_q_exp;
    w_go        = 1'b0;
    w_go_cmd    = (w_new_cmd != CMD_NONE) ? w_new_cmd : r_pend;
    w_sr_nxt    = SR_HOLD;

    unique case (r_state)
      IDLE: w_go = (w_go_cmd != CMD_NONE);
      SET_P, CLR_P: begin
        if (w_new_cmd != CMD_NONE) w_pend_nxt = w_new_cmd;
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - 1'b1;
        end else if (GAP_CYC > 0) begin
          w_state_nxt = GAP;
          w_cnt_nxt   = GAP_LD;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      GAP: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - 1'b1;
          if (w_new_cmd != CMD_NONE) w_pend_nxt = w_new_cmd;
        end else if (w_go_cmd != CMD_NONE) begin
          w_go = 1'b1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    // A launch from IDLE or the last GAP cycle consumes the pending slot
    if (w_go) begin
      w_state_nxt = (w_go_cmd == CMD_SET) ? SET_P : CLR_P;
      w_q_exp_nxt = (w_go_cmd == CMD_SET);
      w_cnt_nxt   = PULSE_LD;
      w_pend_nxt  = CMD_NONE;
    end

    unique case (w_state_nxt)
      SET_P:   w_sr_nxt = SR_SET;
      CLR_P:   w_sr_nxt = SR_CLR;
      default: w_sr_nxt = SR_HOLD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_pend     <= CMD_NONE;
      r_sr       <= SR_HOLD;
      r_q_exp    <= 1'b0;
      r_en       <= 1'b0;
      r_busy     <= 1'b0;
      r_conflict <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_pend     <= w_pend_nxt;
      r_sr       <= w_sr_nxt;
      r_q_exp    <= w_q_exp_nxt;
      r_en       <= 1'b1;
      r_busy     <= (w_state_nxt != IDLE);
      r_conflict <= w_set_stb & w_clr_stb;
    end
  end

  assign bus.s        = r_sr[1];
  assign bus.r        = r_sr[0];
  assign bus.en       = r_en;
  assign bus.busy     = r_busy;
  assign bus.conflict = r_conflict;
  assign bus.q_exp    = r_q_exp;

endmodule

// File: tb/tb_sr_cmd_ctrl.sv
// Scoreboard bench for sr_cmd_ctrl: a cycle-level reference model predicts pulses,
// conflicts and status; a negedge monitor compares them against the DUT.
module tb_sr_cmd_ctrl;

  localparam int DEB   = 4;
  localparam int P     = 2;
  localparam int G     = 1;
  localparam bit CPRIO = 1'b1;
  localparam int HL    = DEB + 2;
  localparam int LAT   = 2 + DEB + 1;

  typedef struct {
    bit is_set;
    int start;
  } pulse_t;

  logic clk = 1'b0;
  logic rst;
  sr_cmd_ctrl_if bus();

  sr_cmd_ctrl #(
    .DEB_CYC(DEB), .PULSE_CYC(P), .GAP_CYC(G), .CLR_PRIORITY(CPRIO)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  int vec  = 0;
  int miss = 0;
  int cyc  = 0;

  pulse_t exp_pulses[$];
  int     exp_conf[$];

  bit hist [2][HL];
  bit lvl  [2];
  bit dly1 [2];
  bit dly2 [2];
  int m_pend;
  int free_at, busy_start, busy_end;
  bit m_q, m_en;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    vec++;
    if (act !== expv) begin
      miss++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic model_reset();
    for (int ch = 0; ch < 2; ch++) begin
      for (int k = 0; k < HL; k++) hist[ch][k] = 1'b0;
      lvl[ch] = 0; dly1[ch] = 0; dly2[ch] = 0;
    end
    m_pend = 0; free_at = 0; busy_start = 0; busy_end = 0;
    m_q = 0; m_en = 0;
    exp_pulses.delete();
    exp_conf.delete();
  endtask

  // Commands: 0 none, 1 set, 2 clear. A lane's level flips once the DEB most recent
  // synchronised samples all disagree with it; the FSM sees the rise two edges later.
  task automatic model_step(input int e);
    bit     rise [2];
    bit     stb  [2];
    bit     flip;
    int     nc;
    pulse_t p;
    m_en = 1;
    for (int ch = 0; ch < 2; ch++) begin
      for (int k = HL - 1; k > 0; k--) hist[ch][k] = hist[ch][k-1];
      hist[ch][0] = (ch == 0) ? bus.set_req : bus.clr_req;
      flip = 1;
      for (int k = 2; k < 2 + DEB; k++) if (hist[ch][k] == lvl[ch]) flip = 0;
      rise[ch] = flip && !lvl[ch];
      if (flip) lvl[ch] = !lvl[ch];
      stb[ch]  = dly2[ch];
      dly2[ch] = dly1[ch];
      dly1[ch] = rise[ch];
    end
    nc = 0;
    if (stb[0] && stb[1]) begin
      exp_conf.push_back(e);
      nc = CPRIO ? 2 : 1;
    end else if (stb[0]) nc = 1;
    else if (stb[1])     nc = 2;
    if (e >= free_at) begin
      if (nc == 0) nc = m_pend;
      if (nc != 0) begin
        p.is_set = (nc == 1);
        p.start  = e;
        exp_pulses.push_back(p);
        m_q        = (nc == 1);
        busy_start = e;
        busy_end   = e + P + G;
        free_at    = busy_end + ((G == 0) ? 1 : 0);
        m_pend     = 0;
      end
    end else if (nc != 0) begin
      m_pend = nc;
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    if (rst) model_reset();
    else     model_step(cyc);
  end

  bit     act = 0;
  int     width;
  bit     exp_start, starting, exp_c;
  pulse_t pp;
  int     junk;

  always @(negedge clk) begin
    chk("s_and_r", bus.s & bus.r, 1'b0);
    chk("en", bus.en, m_en);
    chk("busy", bus.busy, (cyc >= busy_start) && (cyc < busy_end));
    chk("q_exp", bus.q_exp, m_q);
    if (rst) begin
      chk("s_in_reset", bus.s, 1'b0);
      chk("r_in_reset", bus.r, 1'b0);
      chk("conflict_in_reset", bus.conflict, 1'b0);
      act = 0;
    end else begin
      exp_start = (exp_pulses.size() > 0) && (exp_pulses[0].start == cyc);
      starting  = (bus.s || bus.r) && !act;
      if (starting || exp_start) begin
        chk("pulse_start", starting, exp_start);
        if (exp_start) begin
          pp = exp_pulses.pop_front();
          if (starting) chk("pulse_type", bus.s, pp.is_set);
        end
        if (starting) begin act = 1; width = 0; end
      end
      if (act) begin
        if (bus.s || bus.r) width++;
        else begin
          chk("pulse_width", width, P);
          act = 0;
        end
      end
      exp_c = (exp_conf.size() > 0) && (exp_conf[0] == cyc);
      if (bus.conflict || exp_c) begin
        chk("conflict", bus.conflict, exp_c);
        if (exp_c) junk = exp_conf.pop_front();
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic observe(input int n, output int s_first, output int r_first, output int n_conf);
    s_first = -1; r_first = -1; n_conf = 0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      if (bus.s && s_first < 0) s_first = k;
      if (bus.r && r_first < 0) r_first = k;
      if (bus.conflict) n_conf++;
    end
    @(negedge clk); #1;
  endtask

  int sf, rf, nc, guard;
  bit r_seen;

  initial begin
    rst = 1'b1;
    bus.set_req = 1'b0;
    bus.clr_req = 1'b0;

    step(3);
    chk("t1_en_reset", bus.en, 1'b0);
    chk("t1_s_reset", bus.s, 1'b0);
    chk("t1_r_reset", bus.r, 1'b0);
    chk("t1_q_reset", bus.q_exp, 1'b0);
    rst = 1'b0;
    step(1);
    chk("t1_en_after", bus.en, 1'b1);
    step(10);

    bus.set_req = 1'b1;
    observe(20, sf, rf, nc);
    chk("t2_set_latency", sf, LAT);
    chk("t2_no_r", rf, -1);
    chk("t2_q_exp", bus.q_exp, 1'b1);
    chk("t2_busy_done", bus.busy, 1'b0);
    bus.set_req = 1'b0;
    step(12);

    r_seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) bus.clr_req = ~bus.clr_req;
      @(posedge clk); #1;
      r_seen |= bus.r;
      @(negedge clk); #1;
    end
    bus.clr_req = 1'b0;
    observe(15, sf, rf, nc);
    chk("t3_r_during_bounce", r_seen, 1'b0);
    chk("t3_r_after_bounce", rf, -1);
    chk("t3_q_kept", bus.q_exp, 1'b1);

    bus.set_req = 1'b1;
    bus.clr_req = 1'b1;
    observe(20, sf, rf, nc);
    chk("t4_conflict_cycles", nc, 1);
    chk("t4_no_s", sf, -1);
    chk("t4_r_latency", rf, LAT);
    chk("t4_q_exp", bus.q_exp, 1'b0);
    bus.set_req = 1'b0;
    bus.clr_req = 1'b0;
    step(12);

    bus.set_req = 1'b1;
    step(1);
    bus.clr_req = 1'b1;
    observe(20, sf, rf, nc);
    chk("t5_s_start", sf, LAT - 1);
    chk("t5_r_after_gap", rf, LAT - 1 + P + G);
    chk("t5_q_exp", bus.q_exp, 1'b0);
    bus.set_req = 1'b0;
    bus.clr_req = 1'b0;
    step(12);

    bus.set_req = 1'b1;
    guard = 0;
    while (!bus.s && guard < 30) begin step(1); guard++; end
    chk("t6_reached_set", bus.s, 1'b1);
    rst = 1'b1;
    bus.set_req = 1'b0;
    #1;
    chk("t6_s_async", bus.s, 1'b0);
    chk("t6_en_async", bus.en, 1'b0);
    chk("t6_busy_async", bus.busy, 1'b0);
    step(2);
    rst = 1'b0;
    observe(20, sf, rf, nc);
    chk("t6_no_s", sf, -1);
    chk("t6_no_r", rf, -1);
    chk("t6_en_back", bus.en, 1'b1);

    for (int i = 0; i < 60; i++) begin
      bus.set_req = 1'($urandom_range(0, 1));
      bus.clr_req = 1'($urandom_range(0, 1));
      step($urandom_range(1, 10));
    end
    bus.set_req = 1'b0;
    bus.clr_req = 1'b0;
    step(30);
    chk("pulses_drained", exp_pulses.size(), 0);
    chk("conflicts_drained", exp_conf.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
